// File: rtl/fdau_io_pkg.sv
// Shared types and constants for the FDAU optional I/O group.
// State encoding and status words used by the impulse blocks.
package fdau_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [15:0] STATUS_ACTIVE = 16'hffff;
    localparam logic [15:0] STATUS_IDLE   = 16'h0000;

endpackage

// File: rtl/msec_edge.sv
// Rising-edge detector for the millisecond timebase level.
// A level held high for several cycles yields a single tick.
module msec_edge (
    input  logic clock,
    input  logic reset,
    input  logic msec,
    output logic tick
);

    logic msec_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msec_q <= 1'b0;
        end else begin
            msec_q <= msec;
        end
    end

    assign tick = msec & ~msec_q;

endmodule

// File: rtl/impuls_gen.sv
// Programmable impulse train transmitter for the FDAU optional I/O group.
// Emits count pulses of high_ms width separated by low_ms gaps.
module impuls_gen
    import fdau_io_pkg::*;
#(
    parameter int W_MS  = 8,
    parameter int W_CNT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             msec,
    input  logic             start,
    input  logic [W_MS-1:0]  high_ms,
    input  logic [W_MS-1:0]  low_ms,
    input  logic [W_CNT-1:0] count,
    input  logic             abort,
    output logic             impuls_out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      status
);

    state_t            state, state_n;
    logic [W_MS-1:0]   ms_cnt, ms_cnt_n;
    logic [W_MS-1:0]   high_lat, high_lat_n;
    logic [W_MS-1:0]   low_lat, low_lat_n;
    logic [W_CNT-1:0]  pulse_cnt, pulse_cnt_n;
    logic [W_MS-1:0]   high_nz, low_nz;
    logic              tick;
    logic              phase_end;

    msec_edge u_msec_edge (
        .clock (clock),
        .reset (reset),
        .msec  (msec),
        .tick  (tick)
    );

    assign high_nz   = (high_ms == '0) ? W_MS'(1) : high_ms;
    assign low_nz    = (low_ms == '0) ? W_MS'(1) : low_ms;
    // ms_cnt never starts below 1, so <=1 marks the tick that empties it
    assign phase_end = tick && (ms_cnt <= W_MS'(1));

    always_comb begin
        state_n     = state;
        ms_cnt_n    = ms_cnt;
        pulse_cnt_n = pulse_cnt;
        high_lat_n  = high_lat;
        low_lat_n   = low_lat;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        high_lat_n  = high_nz;
                        low_lat_n   = low_nz;
                        pulse_cnt_n = count;
                        ms_cnt_n    = high_nz;
                        state_n     = (count == '0) ? DONE : HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        pulse_cnt_n = (pulse_cnt != '0) ? pulse_cnt - W_CNT'(1) : '0;
                        if (pulse_cnt > W_CNT'(1)) begin
                            ms_cnt_n = low_lat;
                            state_n  = LOW;
                        end else begin
                            ms_cnt_n = '0;
                            state_n  = DONE;
                        end
                    end else if (tick) begin
                        ms_cnt_n = ms_cnt - W_MS'(1);
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        ms_cnt_n = high_lat;
                        state_n  = HIGH;
                    end else if (tick) begin
                        ms_cnt_n = ms_cnt - W_MS'(1);
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ms_cnt     <= '0;
            pulse_cnt  <= '0;
            high_lat   <= '0;
            low_lat    <= '0;
            impuls_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= STATUS_IDLE;
        end else begin
            state      <= state_n;
            ms_cnt     <= ms_cnt_n;
            pulse_cnt  <= pulse_cnt_n;
            high_lat   <= high_lat_n;
            low_lat    <= low_lat_n;
            impuls_out <= (state_n == HIGH);
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
            status     <= (state_n != IDLE) ? STATUS_ACTIVE : STATUS_IDLE;
        end
    end

endmodule

// File: tb/tb_impuls_gen.sv
// Directed bench for impuls_gen: 10-cycle ms period, expected
// per-ms output levels written out by hand.
module tb_impuls_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        msec = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  high_ms = '0;
    logic [7:0]  low_ms = '0;
    logic [7:0]  count = '0;
    logic        impuls_out;
    logic        busy;
    logic        done;
    logic [15:0] status;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int d0;

    logic        s1_done, s1_busy, s1_out;
    logic        e_out, e_busy, e_done;
    logic [15:0] e_status;

    impuls_gen #(.W_MS(8), .W_CNT(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .msec       (msec),
        .start      (start),
        .high_ms    (high_ms),
        .low_ms     (low_ms),
        .count      (count),
        .abort      (abort),
        .impuls_out (impuls_out),
        .busy       (busy),
        .done       (done),
        .status     (status)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // one ms window: msec high for w cycles, 10 cycles total
    task automatic ms_tick(input int w);
        msec = 1'b1;
        step();
        s1_done = done;
        s1_busy = busy;
        s1_out  = impuls_out;
        repeat (w - 1) step();
        msec = 1'b0;
        repeat (10 - w) step();
        e_out    = impuls_out;
        e_busy   = busy;
        e_done   = done;
        e_status = status;
    endtask

    // bits[i] is the expected impuls_out level after tick i+1
    task automatic run_seq(input string tag, input int n, input int w,
                           input logic [15:0] bits);
        for (int i = 0; i < n; i++) begin
            ms_tick(w);
            check($sformatf("%s_t%0d", tag, i + 1), e_out, bits[i]);
        end
    endtask

    task automatic launch(input logic [7:0] h, input logic [7:0] l,
                          input logic [7:0] c);
        high_ms = h;
        low_ms  = l;
        count   = c;
        start   = 1'b1;
        step();
        start   = 1'b0;
        high_ms = 8'd9;
        low_ms  = 8'd9;
        count   = 8'd7;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_out", impuls_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 16'h0000);
        step();
        step();
        reset = 1'b0;
        step();

        // 3 ms high, 2 ms low, 2 pulses
        d0 = done_cnt;
        launch(8'd3, 8'd2, 8'd2);
        check("t1_out_n1", impuls_out, 1'b1);
        check("t1_busy_n1", busy, 1'b1);
        check("t1_status_n1", status, 16'hffff);
        run_seq("t1a", 4, 1, 16'b0011);
        check("t1_status_mid", e_status, 16'hffff);
        check("t1_busy_mid", e_busy, 1'b1);
        run_seq("t1b", 4, 1, 16'b0111);
        check("t1_done_strobe", s1_done, 1'b1);
        check("t1_done_busy", s1_busy, 1'b1);
        check("t1_busy_end", e_busy, 1'b0);
        check("t1_status_end", e_status, 16'h0000);
        check("t1_done_end", e_done, 1'b0);
        check("t1_done_cnt", done_cnt - d0, 1);

        // count 0: done only
        d0 = done_cnt;
        launch(8'd5, 8'd5, 8'd0);
        check("t2_out", impuls_out, 1'b0);
        check("t2_done", done, 1'b1);
        check("t2_busy", busy, 1'b1);
        check("t2_status", status, 16'hffff);
        step();
        check("t2_done_off", done, 1'b0);
        check("t2_busy_off", busy, 1'b0);
        check("t2_status_off", status, 16'h0000);
        check("t2_done_cnt", done_cnt - d0, 1);

        // zero durations, start coinciding with a tick
        d0 = done_cnt;
        high_ms = 8'd0;
        low_ms  = 8'd0;
        count   = 8'd3;
        start   = 1'b1;
        msec    = 1'b1;
        step();
        start   = 1'b0;
        msec    = 1'b0;
        repeat (9) step();
        check("t3_out_pre", impuls_out, 1'b1);
        check("t3_busy_pre", busy, 1'b1);
        run_seq("t3", 5, 1, 16'b01010);
        check("t3_done_strobe", s1_done, 1'b1);
        check("t3_done_cnt", done_cnt - d0, 1);

        // msec held high 5 cycles per ms
        d0 = done_cnt;
        launch(8'd2, 8'd3, 8'd2);
        run_seq("t4", 7, 5, 16'b0110001);
        check("t4_done_strobe", s1_done, 1'b1);
        check("t4_done_cnt", done_cnt - d0, 1);

        // abort in 2nd high phase, then immediate restart
        d0 = done_cnt;
        launch(8'd2, 8'd1, 8'd4);
        run_seq("t5", 3, 1, 16'b101);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_out", impuls_out, 1'b0);
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_done", done, 1'b0);
        check("t5_abort_status", status, 16'h0000);
        launch(8'd1, 8'd1, 8'd1);
        check("t5_restart_busy", busy, 1'b1);
        check("t5_restart_out", impuls_out, 1'b1);
        run_seq("t5b", 1, 1, 16'b0);
        check("t5b_done_strobe", s1_done, 1'b1);
        check("t5_done_cnt", done_cnt - d0, 1);
        abort = 1'b1;
        start = 1'b1;
        count = 8'd2;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("t5_abort_wins", busy, 1'b0);
        step();
        check("t5_abort_wins2", busy, 1'b0);

        // start while busy, then async reset mid-LOW
        launch(8'd2, 8'd3, 8'd2);
        run_seq("t6", 1, 1, 16'b1);
        high_ms = 8'd1;
        count   = 8'd0;
        start   = 1'b1;
        step();
        start   = 1'b0;
        check("t6_busy_start_out", impuls_out, 1'b1);
        check("t6_busy_start_busy", busy, 1'b1);
        check("t6_busy_start_done", done, 1'b0);
        run_seq("t6b", 2, 1, 16'b00);
        check("t6_low_busy", e_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_out", impuls_out, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_status", status, 16'h0000);
        #1 reset = 1'b0;
        run_seq("t6c", 1, 1, 16'b0);
        check("t6_idle_after", e_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
